// File: rtl/store_check_monitor_if.sv
// ---------------------------------------------------------------------------
// store_check_monitor_if
//   Bundles the two buses the store monitor listens to:
//     - the data-memory write port of the core (memWrite/dataAddress/writeData)
//     - the expected-store table load port (cfgValid/cfgIndex/cfgAddr/cfgData/
//       cfgMask)
//   modport master : the side that drives both buses (core / bench)
//   modport slave  : the monitor, which only observes
//   Parameters must match the ones given to store_check_monitor.
// ---------------------------------------------------------------------------
interface store_check_monitor_if #(
  parameter int NUM_CHECKS = 8,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  // A one-entry table still needs a one-bit index port.
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic                  memWrite;
  logic [ADDR_W-1:0]     dataAddress;
  logic [DATA_W-1:0]     writeData;

  logic                  cfgValid;
  logic [IDX_W-1:0]      cfgIndex;
  logic [ADDR_W-1:0]     cfgAddr;
  logic [DATA_W-1:0]     cfgData;
  logic [DATA_W/8-1:0]   cfgMask;

  modport master (
    output memWrite, dataAddress, writeData,
    output cfgValid, cfgIndex, cfgAddr, cfgData, cfgMask
  );

  modport slave (
    input memWrite, dataAddress, writeData,
    input cfgValid, cfgIndex, cfgAddr, cfgData, cfgMask
  );
endinterface

// File: rtl/store_check_monitor.sv
// ---------------------------------------------------------------------------
// store_check_monitor
//   Watches committed stores on a core's data-memory write port and checks
//   them, in order, against a preloaded table of expected (address, data)
//   pairs. Stores inside the inclusive scratch window [ignoreLo, ignoreHi]
//   are skipped. A run that neither completes nor mismatches within
//   TIMEOUT_CYCLES RUN cycles fails with a timeout code.
//
//   Ports:
//     clk, reset      clock, synchronous active-low reset
//     bus (slave)     store port + table load port (store_check_monitor_if)
//     ignoreLo/Hi     scratch window, unsigned, empty when lo > hi
//     start           arm pulse (IDLE only), samples startCount
//     startCount      entries to check, clamped to NUM_CHECKS
//     done/pass/fail  registered verdict, done = pass | fail
//     failCode        0 none, 1 address mismatch, 2 data mismatch, 3 timeout
//     matchCount      entries matched so far
//     cycleCount      RUN cycles elapsed (saturating)
//
//   Build option: STORE_CHECK_BYTEMASK_EN adds a per-byte compare mask to
//   each table entry (loaded from cfgMask). Without it the full data word is
//   compared and cfgMask is not stored.
//
//   The table has no reset on purpose: a table survives reset and can be
//   rerun with another start.
// ---------------------------------------------------------------------------
module store_check_monitor #(
  parameter int NUM_CHECKS     = 8,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int CNT_W = $clog2(NUM_CHECKS + 1),
  localparam int CYC_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  store_check_monitor_if.slave bus,
  input  logic [ADDR_W-1:0]    ignoreLo,
  input  logic [ADDR_W-1:0]    ignoreHi,
  input  logic                 start,
  input  logic [CNT_W-1:0]     startCount,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [1:0]           failCode,
  output logic [CNT_W-1:0]     matchCount,
  output logic [CYC_W-1:0]     cycleCount
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_ADDR    = 2'd1;
  localparam logic [1:0] CODE_DATA    = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(NUM_CHECKS);
  localparam logic [CYC_W-1:0] CYC_SAT     = CYC_W'(TIMEOUT_CYCLES);
  localparam logic [CYC_W-1:0] CYC_TIMEOUT = CYC_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_r;
  logic [CNT_W-1:0]  target_r;

  logic [1:0]        state_n_s;
  logic [CNT_W-1:0]  target_n_s;
  logic [CNT_W-1:0]  match_n_s;
  logic [CYC_W-1:0]  cyc_n_s;
  logic [1:0]        code_n_s;

  logic [ADDR_W-1:0] tbl_addr_r [NUM_CHECKS];
  logic [DATA_W-1:0] tbl_data_r [NUM_CHECKS];

  logic              idx_ok_s;
  logic              tbl_we_s;
  logic [IDX_W-1:0]  cur_idx_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [DATA_W-1:0] cur_data_s;
  logic              in_window_s;
  logic              store_live_s;
  logic              addr_eq_s;
  logic              data_eq_s;
  logic              timeout_s;
  logic [CNT_W-1:0]  start_cnt_s;

  // Indexes that do not name a real entry are silently dropped.
  assign idx_ok_s = (32'(bus.cfgIndex) < 32'(NUM_CHECKS));
  assign tbl_we_s = reset && (state_r == ST_IDLE) && bus.cfgValid && idx_ok_s;

  // matchCount never reaches the latched count while in RUN, so its low
  // bits always address a valid entry.
  assign cur_idx_s  = matchCount[IDX_W-1:0];
  assign cur_addr_s = tbl_addr_r[cur_idx_s];
  assign cur_data_s = tbl_data_r[cur_idx_s];

  // An inverted window (lo > hi) can never hold an address, i.e. it is empty.
  assign in_window_s  = (bus.dataAddress >= ignoreLo) && (bus.dataAddress <= ignoreHi);
  assign store_live_s = bus.memWrite && !in_window_s;
  assign addr_eq_s    = (bus.dataAddress == cur_addr_s);
  assign timeout_s    = (cycleCount == CYC_TIMEOUT);
  assign start_cnt_s  = (startCount > CNT_MAX) ? CNT_MAX : startCount;

`ifdef STORE_CHECK_BYTEMASK_EN
  logic [DATA_W/8-1:0] tbl_mask_r [NUM_CHECKS];

  // Widen one enable bit per byte into a full-width bit mask.
  function automatic logic [DATA_W-1:0] expand_mask(input logic [DATA_W/8-1:0] m);
    logic [DATA_W-1:0] e;
    e = {DATA_W{1'b0}};
    for (int b = 0; b < DATA_W / 8; b++) begin
      e[8*b +: 8] = {8{m[b]}};
    end
    return e;
  endfunction

  // Mask storage shares the load strobe with the address/data table.
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      tbl_mask_r[bus.cfgIndex] <= bus.cfgMask;
    end
  end

  // Disabled bytes are forced equal; an all-zero mask matches on address only.
  assign data_eq_s = (((bus.writeData ^ cur_data_s) & expand_mask(tbl_mask_r[cur_idx_s]))
                      == {DATA_W{1'b0}});
`else
  logic unused_mask_s;
  assign unused_mask_s = ^bus.cfgMask;
  assign data_eq_s     = (bus.writeData == cur_data_s);
`endif

  // Expected-store table load; deliberately not reset.
  always_ff @(posedge clk) begin
    if (tbl_we_s) begin
      tbl_addr_r[bus.cfgIndex] <= bus.cfgAddr;
      tbl_data_r[bus.cfgIndex] <= bus.cfgData;
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_n_s  = state_r;
    target_n_s = target_r;
    match_n_s  = matchCount;
    cyc_n_s    = cycleCount;
    code_n_s   = failCode;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          target_n_s = start_cnt_s;
          match_n_s  = {CNT_W{1'b0}};
          cyc_n_s    = {CYC_W{1'b0}};
          code_n_s   = CODE_NONE;
          state_n_s  = (start_cnt_s == {CNT_W{1'b0}}) ? ST_PASS : ST_RUN;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Completing match beats compare failure, which beats timeout.
        if (store_live_s && !addr_eq_s) begin
          state_n_s = ST_FAIL;
          code_n_s  = CODE_ADDR;
        end else if (store_live_s && !data_eq_s) begin
          state_n_s = ST_FAIL;
          code_n_s  = CODE_DATA;
        end else if (store_live_s) begin
          match_n_s = matchCount + 1'b1;
          if (match_n_s == target_r) begin
            state_n_s = ST_PASS;
          end else if (timeout_s) begin
            state_n_s = ST_FAIL;
            code_n_s  = CODE_TIMEOUT;
          end else begin
            state_n_s = ST_RUN;
          end
        end else if (timeout_s) begin
          state_n_s = ST_FAIL;
          code_n_s  = CODE_TIMEOUT;
        end else begin
          state_n_s = ST_RUN;
        end
        // The count freezes on the deciding cycle, so a timeout reports
        // TIMEOUT_CYCLES-1 elapsed cycles.
        if ((state_n_s == ST_RUN) && (cycleCount != CYC_SAT)) begin
          cyc_n_s = cycleCount + 1'b1;
        end else begin
          cyc_n_s = cycleCount;
        end
      end
      ST_PASS: begin
        state_n_s = ST_PASS;
      end
      ST_FAIL: begin
        state_n_s = ST_FAIL;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and verdict registers; verdict flags decode the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      target_r   <= {CNT_W{1'b0}};
      matchCount <= {CNT_W{1'b0}};
      cycleCount <= {CYC_W{1'b0}};
      failCode   <= CODE_NONE;
      pass       <= 1'b0;
      fail       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      target_r   <= target_n_s;
      matchCount <= match_n_s;
      cycleCount <= cyc_n_s;
      failCode   <= code_n_s;
      pass       <= (state_n_s == ST_PASS);
      fail       <= (state_n_s == ST_FAIL);
      done       <= (state_n_s == ST_PASS) || (state_n_s == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_store_check_monitor.sv
// Bench for store_check_monitor: directed test-plan cases plus randomized
// runs scored against a run-level reference model (walk the stores, skip the
// scratch window, compare in order, stop at first mismatch/completion/timeout).
module tb_store_check_monitor;

  localparam int NUM     = 5;
  localparam int TMO     = 20;
  localparam int RUN_LEN = 24;
  localparam int CNT_W   = $clog2(NUM + 1);
  localparam int CYC_W   = $clog2(TMO + 1);

  logic             clk;
  logic             reset;
  logic [31:0]      ignoreLo;
  logic [31:0]      ignoreHi;
  logic             start;
  logic [CNT_W-1:0] startCount;
  logic             done;
  logic             pass;
  logic             fail;
  logic [1:0]       failCode;
  logic [CNT_W-1:0] matchCount;
  logic [CYC_W-1:0] cycleCount;

  store_check_monitor_if #(.NUM_CHECKS(NUM), .ADDR_W(32), .DATA_W(32)) bus ();

  store_check_monitor #(
    .NUM_CHECKS(NUM), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ignoreLo(ignoreLo), .ignoreHi(ignoreHi),
    .start(start), .startCount(startCount),
    .done(done), .pass(pass), .fail(fail), .failCode(failCode),
    .matchCount(matchCount), .cycleCount(cycleCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference table and per-run store stimulus
  logic [31:0] m_addr [NUM];
  logic [31:0] m_data [NUM];
  logic [3:0]  m_mask [NUM];
  logic        s_we   [RUN_LEN];
  logic [31:0] s_addr [RUN_LEN];
  logic [31:0] s_data [RUN_LEN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.memWrite = 1'b0; bus.dataAddress = 32'h0; bus.writeData = 32'h0;
    bus.cfgValid = 1'b0; bus.cfgIndex = 3'd0; bus.cfgAddr = 32'h0;
    bus.cfgData = 32'h0; bus.cfgMask = 4'h0;
    start = 1'b0; startCount = 3'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.cfgValid = 1'b1; bus.cfgIndex = 3'(idx);
    bus.cfgAddr = a; bus.cfgData = d; bus.cfgMask = m;
    tick();
    bus.cfgValid = 1'b0;
    if (idx < NUM) begin
      m_addr[idx] = a; m_data[idx] = d; m_mask[idx] = m;
    end
  endtask

  task automatic clear_stores();
    for (int r = 0; r < RUN_LEN; r++) begin
      s_we[r] = 1'b0; s_addr[r] = 32'h0; s_data[r] = 32'h0;
    end
  endtask

  function automatic bit data_ok(input logic [31:0] got, input int k);
`ifdef STORE_CHECK_BYTEMASK_EN
    for (int b = 0; b < 4; b++) begin
      if (m_mask[k][b] && (got[8*b +: 8] != m_data[k][8*b +: 8])) return 1'b0;
    end
    return 1'b1;
`else
    return got == m_data[k];
`endif
  endfunction

  // Walk the stimulus and report the verdict cycle (-1 = at start), code,
  // matched entries and elapsed cycles.
  task automatic predict(input int sc, output int dec, output int code,
                         output int mcnt, output int cyc);
    int eff;
    int k;
    eff = (sc > NUM) ? NUM : sc;
    k = 0;
    dec = -1; code = 0; mcnt = 0; cyc = 0;
    if (eff == 0) return;
    for (int r = 0; r < RUN_LEN; r++) begin
      if (s_we[r] && !((s_addr[r] >= ignoreLo) && (s_addr[r] <= ignoreHi))) begin
        if (s_addr[r] != m_addr[k]) begin
          dec = r; code = 1; mcnt = k; cyc = r; return;
        end
        if (!data_ok(s_data[r], k)) begin
          dec = r; code = 2; mcnt = k; cyc = r; return;
        end
        k++;
        if (k == eff) begin
          dec = r; code = 0; mcnt = k; cyc = r; return;
        end
      end
      if (r == TMO - 1) begin
        dec = r; code = 3; mcnt = k; cyc = r; return;
      end
    end
  endtask

  // Start a run, play the stores (with junk cfg/start traffic that must be
  // ignored) and score every cycle against the model.
  task automatic run_check(input int sc);
    int dec, code, mcnt, cyc;
    predict(sc, dec, code, mcnt, cyc);
    start = 1'b1; startCount = 3'(sc);
    tick();
    start = 1'b0;
    chk("start_done", 64'(done), 64'(dec < 0));
    for (int r = 0; r < RUN_LEN; r++) begin
      bus.memWrite = s_we[r]; bus.dataAddress = s_addr[r]; bus.writeData = s_data[r];
      bus.cfgValid = 1'($urandom_range(0, 1)); bus.cfgIndex = 3'($urandom_range(0, 7));
      bus.cfgAddr = $urandom(); bus.cfgData = $urandom(); bus.cfgMask = 4'($urandom());
      start = ($urandom_range(0, 3) == 0); startCount = 3'($urandom_range(0, 7));
      tick();
      chk("run_done", 64'(done), 64'((dec < 0) || (r >= dec)));
      if (!((dec < 0) || (r >= dec))) chk("run_cycles", 64'(cycleCount), 64'(r + 1));
    end
    idle_inputs();
    chk("pass", 64'(pass), 64'(code == 0));
    chk("fail", 64'(fail), 64'(code != 0));
    chk("failCode", 64'(failCode), 64'(code));
    chk("matchCount", 64'(matchCount), 64'(mcnt));
    chk("cycleCount", 64'(cycleCount), 64'(cyc));
  endtask

  initial begin
    int g, p, sc;
    logic [31:0] lo, hi;
    reset = 1'b0;
    ignoreLo = 32'd1; ignoreHi = 32'd0;
    idle_inputs();
    tick(); tick();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_code", 64'(failCode), 64'd0);
    chk("rst_match", 64'(matchCount), 64'd0);
    chk("rst_cycles", 64'(cycleCount), 64'd0);
    reset = 1'b1;

    // Scratch store skipped, second store completes
    load(0, 32'd100, 32'd25, 4'hF);
    ignoreLo = 32'd96; ignoreHi = 32'd96;
    clear_stores();
    s_we[0] = 1'b1; s_addr[0] = 32'd96;  s_data[0] = 32'd7;
    s_we[1] = 1'b1; s_addr[1] = 32'd100; s_data[1] = 32'd25;
    run_check(1);
    chk("t1_pass", 64'(pass), 64'd1);
    chk("t1_match", 64'(matchCount), 64'd1);

    // Address mismatch
    do_reset();
    clear_stores();
    s_we[0] = 1'b1; s_addr[0] = 32'd104; s_data[0] = 32'd25;
    run_check(1);
    chk("t2_code", 64'(failCode), 64'd1);
    chk("t2_match", 64'(matchCount), 64'd0);

    // Data mismatch on second entry
    do_reset();
    load(0, 32'h10, 32'hAA, 4'hF);
    load(1, 32'h14, 32'hBB, 4'hF);
    clear_stores();
    s_we[0] = 1'b1; s_addr[0] = 32'h10; s_data[0] = 32'hAA;
    s_we[1] = 1'b1; s_addr[1] = 32'h14; s_data[1] = 32'hBC;
    run_check(2);
    chk("t3_code", 64'(failCode), 64'd2);
    chk("t3_match", 64'(matchCount), 64'd1);

    // Timeout, then completion on the timeout cycle itself
    do_reset();
    clear_stores();
    run_check(1);
    chk("t4_code", 64'(failCode), 64'd3);
    chk("t4_cycles", 64'(cycleCount), 64'd19);
    do_reset();
    s_we[TMO-1] = 1'b1; s_addr[TMO-1] = 32'h10; s_data[TMO-1] = 32'hAA;
    run_check(1);
    chk("t4b_pass", 64'(pass), 64'd1);
    chk("t4b_cycles", 64'(cycleCount), 64'd19);

    // Reset mid-run after one match, then rerun on the retained table
    do_reset();
    load(0, 32'h40, 32'd1, 4'hF);
    load(1, 32'h44, 32'd2, 4'hF);
    ignoreLo = 32'd1; ignoreHi = 32'd0;
    start = 1'b1; startCount = 3'd2;
    tick();
    start = 1'b0;
    bus.memWrite = 1'b1; bus.dataAddress = 32'h40; bus.writeData = 32'd1;
    tick();
    chk("t5_mid_match", 64'(matchCount), 64'd1);
    bus.dataAddress = 32'h44; bus.writeData = 32'd2;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    chk("t5_done", 64'(done), 64'd0);
    chk("t5_pass", 64'(pass), 64'd0);
    chk("t5_fail", 64'(fail), 64'd0);
    chk("t5_code", 64'(failCode), 64'd0);
    chk("t5_match", 64'(matchCount), 64'd0);
    chk("t5_cycles", 64'(cycleCount), 64'd0);
    clear_stores();
    s_we[0] = 1'b1; s_addr[0] = 32'h40; s_data[0] = 32'd1;
    s_we[2] = 1'b1; s_addr[2] = 32'h44; s_data[2] = 32'd2;
    run_check(2);
    chk("t5_rerun_pass", 64'(pass), 64'd1);

    // Byte mask
    do_reset();
    load(0, 32'h20, 32'h12345678, 4'b0001);
    clear_stores();
    s_we[0] = 1'b1; s_addr[0] = 32'h20; s_data[0] = 32'hFFFFFF78;
    run_check(1);
`ifdef STORE_CHECK_BYTEMASK_EN
    chk("t6_pass", 64'(pass), 64'd1);
`else
    chk("t6_code", 64'(failCode), 64'd2);
`endif

    // Table write and start in the same cycle
    do_reset();
    load(0, 32'h84, 32'd9, 4'hF);
    bus.cfgValid = 1'b1; bus.cfgIndex = 3'd0; bus.cfgAddr = 32'h80;
    bus.cfgData = 32'd5; bus.cfgMask = 4'hF;
    m_addr[0] = 32'h80; m_data[0] = 32'd5; m_mask[0] = 4'hF;
    start = 1'b1; startCount = 3'd1;
    tick();
    idle_inputs();
    bus.memWrite = 1'b1; bus.dataAddress = 32'h80; bus.writeData = 32'd5;
    tick();
    idle_inputs();
    chk("t7_pass", 64'(pass), 64'd1);
    chk("t7_match", 64'(matchCount), 64'd1);

    // Randomized runs
    do_reset();
    for (int i = 0; i < NUM; i++) begin
      load(i, 32'h100 + 32'(4 * $urandom_range(0, 15)), 32'($urandom_range(0, 255)), 4'($urandom()));
    end
    for (int run = 0; run < 40; run++) begin
      do_reset();
      for (int j = 0; j < $urandom_range(0, 4); j++) begin
        load($urandom_range(0, 6), 32'h100 + 32'(4 * $urandom_range(0, 15)),
             32'($urandom_range(0, 255)), 4'($urandom()));
      end
      lo = 32'h100 + 32'(4 * $urandom_range(0, 15));
      hi = 32'h100 + 32'(4 * $urandom_range(0, 15));
      ignoreLo = lo; ignoreHi = hi;
      sc = $urandom_range(0, 7);
      g = 0;
      for (int r = 0; r < RUN_LEN; r++) begin
        p = $urandom_range(0, 99);
        s_we[r] = 1'b1;
        s_addr[r] = 32'h100 + 32'(4 * $urandom_range(0, 15));
        s_data[r] = 32'($urandom_range(0, 255));
        if (p < 20) begin
          s_we[r] = 1'b0;
        end else if (p < 30) begin
          s_addr[r] = lo;
        end else if (p < 86) begin
          s_addr[r] = m_addr[g % NUM]; s_data[r] = m_data[g % NUM]; g++;
        end else if (p < 93) begin
          s_addr[r] = m_addr[g % NUM]; s_data[r] = m_data[g % NUM] ^ 32'h1;
        end else begin
          s_we[r] = 1'b1;
        end
      end
      run_check(sc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
